// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped bridge between the CPU memory stage and a
// byte-wide UART, with TX/RX FIFOs, sticky error flags and a count register.
module uart_mmio_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int unsigned TX_AW     = 3,
    parameter int unsigned RX_AW     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ls_ctrl,
    input  logic        mem_to_reg,
    input  logic        stall,
    output logic [31:0] rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};

    // FIFO storage is deliberately not reset; every read of it is gated by count.
    logic [7:0] tx_mem [2**TX_AW];
    logic [7:0] rx_mem [2**RX_AW];

    logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic             tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

    logic [31:0] off;
    logic        sel_txst, sel_rxst, sel_txd, sel_rxd, sel_cnt, sel_clr;
    logic        is_store, is_load, fire;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_ovf_set, rx_udf_set, flag_clr;
    logic [7:0]  rx_head;
    logic        unused_wdata;

    assign off      = addr - BASE_ADDR;
    assign sel_txst = (off == 32'h00);
    assign sel_rxst = (off == 32'h04);
    assign sel_txd  = (off == 32'h08);
    assign sel_rxd  = (off == 32'h0C);
    assign sel_cnt  = (off == 32'h10);
    assign sel_clr  = (off == 32'h14);

    assign is_store = ls_ctrl[2] & (ls_ctrl != 3'b100);
    assign is_load  = mem_to_reg;
    assign fire     = (is_store | is_load) & ~stall;

    assign tx_full  = (tx_cnt_q == TX_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL);
    assign rx_empty = (rx_cnt_q == '0);

    // Full/empty are taken from the registered counts, so a same-cycle pop
    // never makes room for a push (and vice versa).
    assign tx_push    = fire & is_store & sel_txd & ~tx_full;
    assign tx_ovf_set = fire & is_store & sel_txd & tx_full;
    assign tx_pop     = ~tx_empty & uart_din_ready;
    assign rx_push    = uart_dout_valid & ~rx_full;
    assign rx_pop     = fire & is_load & sel_rxd & ~rx_empty;
    assign rx_udf_set = fire & is_load & sel_rxd & rx_empty;
    assign flag_clr   = fire & is_store & sel_clr;

    assign rx_head         = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
    assign uart_din        = tx_empty ? 8'h00 : tx_mem[tx_rd_q];
    assign uart_din_valid  = ~tx_empty;
    assign uart_dout_ready = ~rx_full;
    assign unused_wdata    = ^wdata[29:8];

    // Read mux: combinational from current state and address.
    always_comb begin
        rdata = '0;
        if (sel_txst)      rdata = {31'd0, ~tx_full};
        else if (sel_rxst) rdata = {31'd0, ~rx_empty};
        else if (sel_rxd)  rdata = {24'd0, rx_head};
        else if (sel_cnt)  rdata = {tx_ovf_q, rx_udf_q, 6'd0, 8'(rx_cnt_q), 8'd0, 8'(tx_cnt_q)};
    end

    // Next-state for pointers, counts and sticky flags (set beats clear).
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push) tx_wr_d = tx_wr_q + TX_AW'(1);
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_AW'(1);
        if (tx_push & ~tx_pop) tx_cnt_d = tx_cnt_q + (TX_AW+1)'(1);
        if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - (TX_AW+1)'(1);
        if (rx_push) rx_wr_d = rx_wr_q + RX_AW'(1);
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_AW'(1);
        if (rx_push & ~rx_pop) rx_cnt_d = rx_cnt_q + (RX_AW+1)'(1);
        if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - (RX_AW+1)'(1);
        tx_ovf_d = (tx_ovf_q & ~(flag_clr & wdata[31])) | tx_ovf_set;
        rx_udf_d = (rx_udf_q & ~(flag_clr & wdata[30])) | rx_udf_set;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    // FIFO data writes.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= wdata[7:0];
        if (rx_push) rx_mem[rx_wr_q] <= uart_dout;
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo (depth 8 each side).
module tb_uart_mmio_fifo;

    localparam logic [31:0] B = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  ls_ctrl;
    logic        mem_to_reg, stall;
    logic [7:0]  uart_din, uart_dout;
    logic        uart_din_valid, uart_din_ready, uart_dout_valid, uart_dout_ready;

    int vectors = 0;
    int miscompares = 0;

    uart_mmio_fifo #(.BASE_ADDR(B), .TX_AW(3), .RX_AW(3)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .ls_ctrl(ls_ctrl),
        .mem_to_reg(mem_to_reg), .stall(stall), .rdata(rdata),
        .uart_din(uart_din), .uart_din_valid(uart_din_valid),
        .uart_din_ready(uart_din_ready), .uart_dout(uart_dout),
        .uart_dout_valid(uart_dout_valid), .uart_dout_ready(uart_dout_ready)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr = '0; wdata = '0; ls_ctrl = 3'b000; mem_to_reg = 1'b0; stall = 1'b0;
    endtask

    // Side-effect-free register read (no load, no store).
    task automatic rd(input string tag, input logic [31:0] o, input logic [31:0] exp);
        addr = B + o; ls_ctrl = 3'b000; mem_to_reg = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic st(input logic [31:0] o, input logic [2:0] ls, input logic [31:0] d);
        addr = B + o; ls_ctrl = ls; wdata = d; mem_to_reg = 1'b0;
        tick();
        idle();
    endtask

    task automatic ld(input string tag, input logic [31:0] exp);
        addr = B + 32'h0C; ls_ctrl = 3'b010; mem_to_reg = 1'b1;
        #1;
        chk(tag, rdata, exp);
        tick();
        idle();
    endtask

    task automatic rx_in(input logic [7:0] b);
        uart_dout = b; uart_dout_valid = 1'b1;
        tick();
        uart_dout_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; uart_din_ready = 1'b0; uart_dout = '0; uart_dout_valid = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_din_valid", {31'd0, uart_din_valid}, 32'd0);
        chk("rst_dout_ready", {31'd0, uart_dout_ready}, 32'd1);
        chk("rst_din", {24'd0, uart_din}, 32'd0);
        rd("rst_r00", 32'h00, 32'd1);
        rd("rst_r04", 32'h04, 32'd0);
        rd("rst_r10", 32'h10, 32'd0);

        // 1: single SB to TX
        st(32'h08, 3'b101, 32'h0000_0041);
        chk("t1_valid", {31'd0, uart_din_valid}, 32'd1);
        chk("t1_din", {24'd0, uart_din}, 32'h41);
        rd("t1_cnt", 32'h10, 32'h0000_0001);

        // 2: fill TX (SH/SW also push wdata[7:0]), overflow, W1C
        st(32'h08, 3'b110, 32'hFFFF_FF42);
        for (int i = 0; i < 6; i++) st(32'h08, 3'b111, 32'h1234_5643 + 32'(i));
        rd("t2_full_r00", 32'h00, 32'd0);
        rd("t2_cnt8", 32'h10, 32'h0000_0008);
        st(32'h08, 3'b101, 32'h0000_0099);
        rd("t2_ovf", 32'h10, 32'h8000_0008);
        chk("t2_head", {24'd0, uart_din}, 32'h41);
        st(32'h14, 3'b111, 32'h8000_0000);
        rd("t2_clr", 32'h10, 32'h0000_0008);

        // 5a: full TX, store and pop in the same cycle -> store dropped
        uart_din_ready = 1'b1;
        addr = B + 32'h08; ls_ctrl = 3'b101; wdata = 32'h77;
        tick();
        uart_din_ready = 1'b0;
        idle();
        rd("t5_tx_ovf_cnt7", 32'h10, 32'h8000_0007);
        uart_din_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("t5_drain", {24'd0, uart_din}, 32'h42 + 32'(i));
            tick();
        end
        uart_din_ready = 1'b0;
        chk("t5_drained_valid", {31'd0, uart_din_valid}, 32'd0);
        rd("t5_drained_cnt", 32'h10, 32'h8000_0000);
        st(32'h14, 3'b111, 32'h8000_0000);
        rd("t5_clr", 32'h10, 32'h0000_0000);

        // 3: RX two bytes, two pops, underflow, W1C of bit30
        rx_in(8'h55);
        rx_in(8'hAA);
        rd("t3_cnt2", 32'h10, 32'h0002_0000);
        rd("t3_r04", 32'h04, 32'd1);
        ld("t3_pop55", 32'h55);
        ld("t3_popAA", 32'hAA);
        ld("t3_pop_empty", 32'h00);
        rd("t3_udf", 32'h10, 32'h4000_0000);
        st(32'h14, 3'b111, 32'h4000_0000);
        rd("t3_clr", 32'h10, 32'h0000_0000);

        // 4: stalled load has no side effect
        rx_in(8'h33);
        addr = B + 32'h0C; ls_ctrl = 3'b010; mem_to_reg = 1'b1; stall = 1'b1;
        #1;
        chk("t4_stall_rdata", rdata, 32'h33);
        tick();
        idle();
        rd("t4_stall_cnt", 32'h10, 32'h0001_0000);
        ld("t4_pop", 32'h33);
        rd("t4_cnt0", 32'h10, 32'h0000_0000);

        // 5b: RX at depth-1, simultaneous push+pop, then full
        for (int i = 0; i < 7; i++) rx_in(8'h10 + 8'(i));
        rd("t5_rx_cnt7", 32'h10, 32'h0007_0000);
        uart_dout = 8'h17; uart_dout_valid = 1'b1;
        addr = B + 32'h0C; ls_ctrl = 3'b010; mem_to_reg = 1'b1;
        #1;
        chk("t5_pushpop_rdata", rdata, 32'h10);
        tick();
        uart_dout_valid = 1'b0;
        idle();
        rd("t5_pushpop_cnt", 32'h10, 32'h0007_0000);
        rx_in(8'h18);
        chk("t5_rx_full_ready", {31'd0, uart_dout_ready}, 32'd0);
        rx_in(8'h19);
        rd("t5_rx_full_cnt", 32'h10, 32'h0008_0000);
        for (int i = 0; i < 5; i++) ld("t5_rx_order", 32'h11 + 32'(i));

        // 6: reset mid-transfer with 3 bytes queued on each side
        for (int i = 0; i < 3; i++) st(32'h08, 3'b101, 32'hA1 + 32'(i));
        rd("t6_pre_cnt", 32'h10, 32'h0003_0003);
        uart_din_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_din_valid", {31'd0, uart_din_valid}, 32'd0);
        chk("t6_din", {24'd0, uart_din}, 32'd0);
        chk("t6_dout_ready", {31'd0, uart_dout_ready}, 32'd1);
        rd("t6_cnt", 32'h10, 32'h0000_0000);
        rd("t6_r0c", 32'h0C, 32'h0000_0000);
        tick();
        rst = 1'b0;
        uart_din_ready = 1'b0;
        tick();
        rd("t6_r00", 32'h00, 32'd1);
        rd("t6_r04", 32'h04, 32'd0);

        // Unmapped addresses read zero
        rd("unmap_18", 32'h18, 32'd0);
        addr = 32'h0000_0000;
        #1;
        chk("unmap_low", rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
